// File: rtl/pwm_duty_decoder.sv
// Measures period and high time of a sampled PWM line, once per PWM period,
// and flags a line that has stopped toggling (stuck high or stuck low).
module pwm_duty_decoder #(
  parameter int PWM_INTERVAL = 1200,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int TIMEOUT      = 2 * PWM_INTERVAL,
  localparam int CW          = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pwm_in,
  output logic [CW-1:0] duty,
  output logic [CW-1:0] period,
  output logic          valid,
  output logic          stuck
);

  localparam logic [CW-1:0] TMO      = CW'(TIMEOUT);
  localparam logic [CW-1:0] FULL     = CW'(PWM_INTERVAL);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_MEAS,
    ST_STUCK
  } state_t;

  state_t        state, state_nx;
  logic          s_p0, s_sync, s_prev;
  logic          rise;
  logic [CW-1:0] pcnt, pcnt_nx;
  logic [CW-1:0] hcnt, hcnt_nx;
  logic [CW-1:0] duty_nx, period_nx;
  logic          valid_nx, stuck_nx;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic inc);
    if (inc && (v != TMO)) return v + CNT_ONE;
    return v;
  endfunction

  // stage p0..p2: polarity fix, two-flop synchronizer, edge-detect delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_p0   <= 1'b0;
      s_sync <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s_p0   <= pwm_in ^ ACTIVE_LOW;
      s_sync <= s_p0;
      s_prev <= s_sync;
    end
  end

  assign rise = s_sync & ~s_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_WAIT;
      pcnt   <= '0;
      hcnt   <= '0;
      duty   <= '0;
      period <= '0;
      valid  <= 1'b0;
      stuck  <= 1'b0;
    end else begin
      state  <= state_nx;
      pcnt   <= pcnt_nx;
      hcnt   <= hcnt_nx;
      duty   <= duty_nx;
      period <= period_nx;
      valid  <= valid_nx;
      stuck  <= stuck_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    pcnt_nx   = pcnt;
    hcnt_nx   = hcnt;
    duty_nx   = duty;
    period_nx = period;
    valid_nx  = 1'b0;
    stuck_nx  = stuck;
    case (state)
      ST_WAIT: begin
        if (rise) begin
          pcnt_nx  = CNT_ONE;
          hcnt_nx  = CNT_ONE;
          state_nx = ST_MEAS;
        end
      end
      ST_MEAS: begin
        // a rise takes priority over a simultaneous timeout
        if (rise) begin
          duty_nx   = hcnt;
          period_nx = pcnt;
          valid_nx  = 1'b1;
          pcnt_nx   = CNT_ONE;
          hcnt_nx   = CNT_ONE;
        end else if (pcnt == TMO) begin
          state_nx  = ST_STUCK;
          stuck_nx  = 1'b1;
          valid_nx  = 1'b1;
          period_nx = CNT_ZERO;
          duty_nx   = s_sync ? FULL : CNT_ZERO;
        end else begin
          pcnt_nx = sat_inc(pcnt, 1'b1);
          hcnt_nx = sat_inc(hcnt, s_sync);
        end
      end
      ST_STUCK: begin
        if (rise) begin
          stuck_nx = 1'b0;
          pcnt_nx  = CNT_ONE;
          hcnt_nx  = CNT_ONE;
          state_nx = ST_MEAS;
        end
      end
      default: state_nx = ST_WAIT;
    endcase
  end

endmodule
